// File: rtl/anton_neopixel_stream_if.sv
// Register-block / pixel-RAM side of the neopixel serialiser: frame controls in, RAM index out,
// RAM byte in, phase and end-of-gap sync out.
interface anton_neopixel_stream_if #(
  parameter int unsigned BUFFER_BITS = 3
);
  logic [12:0]            regMax;
  logic                   regCtrlLimit;
  logic                   regCtrlRun;
  logic                   regCtrl32bit;
  logic                   regCtrlInit;
  logic [BUFFER_BITS-1:0] pixelIxComb;
  logic [7:0]             pixelByte;
  logic                   state;
  logic                   streamSyncOf;

  modport master (
    output regMax, regCtrlLimit, regCtrlRun, regCtrl32bit, regCtrlInit, pixelByte,
    input  pixelIxComb, state, streamSyncOf
  );

  modport slave (
    input  regMax, regCtrlLimit, regCtrlRun, regCtrl32bit, regCtrlInit, pixelByte,
    output pixelIxComb, state, streamSyncOf
  );
endinterface

// File: rtl/anton_neopixel_stream.sv
// WS2812-style serialiser: walks the pixel RAM byte by byte, sends each byte MSB-first,
// then holds a low latch gap and pulses streamSyncOf on its last clock.
module anton_neopixel_stream #(
  parameter int unsigned BUFFER_END   = 7,
  parameter int unsigned BIT_CYCLES   = 10,
  parameter int unsigned T0H_CYCLES   = 3,
  parameter int unsigned T1H_CYCLES   = 6,
  parameter int unsigned RESET_CYCLES = 400
) (
  input  logic                   busClk,
  input  logic                   busReset,
  anton_neopixel_stream_if.slave bus,
  output logic                   neoData
);
  localparam int unsigned BUFFER_BITS = $clog2(BUFFER_END + 1);
  localparam int unsigned IX_W        = BUFFER_BITS + 1;
  localparam int unsigned BIT_CNT_W   = $clog2(BIT_CYCLES);
  localparam int unsigned GAP_CNT_W   = $clog2(RESET_CYCLES);
  localparam int unsigned MAX_W       = 13;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_GAP} fsm_t;

  fsm_t                   r_fsm;
  fsm_t                   w_fsm_nxt;
  logic [BIT_CNT_W-1:0]   r_bit_cnt;
  logic [2:0]             r_bit_num;
  logic [BUFFER_BITS-1:0] r_byte_ix;
  logic [BUFFER_BITS-1:0] r_last_ix;
  logic                   r_32bit;
  logic [7:0]             r_shift;
  logic [GAP_CNT_W-1:0]   r_gap_cnt;
  logic                   r_sync;

  logic                   w_bit_end;
  logic                   w_byte_first;
  logic                   w_byte_end;
  logic                   w_cur_bit;
  logic [BIT_CNT_W-1:0]   w_high_cycles;
  logic [IX_W-1:0]        w_ix_inc;
  logic [IX_W-1:0]        w_ix_nxt;
  logic                   w_last_byte;
  logic                   w_gap_end;
  logic [BUFFER_BITS-1:0] w_last_ix;

  assign w_bit_end     = (r_bit_cnt == BIT_CNT_W'(BIT_CYCLES - 1));
  assign w_byte_first  = (r_bit_num == 3'd0) && (r_bit_cnt == '0);
  assign w_byte_end    = w_bit_end && (r_bit_num == 3'd7);
  // The RAM word only arrives on the first clock of a byte, so that clock uses it directly.
  assign w_cur_bit     = w_byte_first ? bus.pixelByte[7] : r_shift[7];
  assign w_high_cycles = w_cur_bit ? BIT_CNT_W'(T1H_CYCLES) : BIT_CNT_W'(T0H_CYCLES);

  // 32-bit pixels skip every fourth byte; one extra index bit keeps the end compare wrap-free.
  assign w_ix_inc    = {1'b0, r_byte_ix} + IX_W'(1);
  assign w_ix_nxt    = (r_32bit && (w_ix_inc[1:0] == 2'b11)) ? w_ix_inc + IX_W'(1) : w_ix_inc;
  assign w_last_byte = (w_ix_nxt > {1'b0, r_last_ix});
  assign w_gap_end   = (r_gap_cnt == GAP_CNT_W'(RESET_CYCLES - 1));

  assign w_last_ix = !bus.regCtrlLimit                    ? BUFFER_BITS'(BUFFER_END) :
                     (bus.regMax > MAX_W'(BUFFER_END))    ? BUFFER_BITS'(BUFFER_END) :
                                                            bus.regMax[BUFFER_BITS-1:0];

  assign bus.streamSyncOf = r_sync;

  always_ff @(posedge busClk) begin
    if (busReset) r_fsm <= S_IDLE;
    else          r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      S_IDLE:  if (bus.regCtrlRun)              w_fsm_nxt = S_DATA;
      S_DATA:  if (w_byte_end && w_last_byte)   w_fsm_nxt = S_GAP;
      S_GAP:   if (w_gap_end)                   w_fsm_nxt = S_IDLE;
      default:                                  w_fsm_nxt = S_IDLE;
    endcase
    if (bus.regCtrlInit) w_fsm_nxt = S_IDLE;
  end

  always_comb begin
    neoData         = 1'b0;
    bus.pixelIxComb = '0;
    bus.state       = 1'b1;
    if (r_fsm == S_DATA) begin
      bus.state       = 1'b0;
      neoData         = (r_bit_cnt < w_high_cycles);
      bus.pixelIxComb = r_byte_ix;
      if (w_byte_end) bus.pixelIxComb = w_last_byte ? '0 : w_ix_nxt[BUFFER_BITS-1:0];
    end
  end

  // Datapath; IDLE re-arms every counter so an aborted frame leaves nothing behind.
  always_ff @(posedge busClk) begin
    if (busReset) begin
      r_bit_cnt <= '0;
      r_bit_num <= '0;
      r_byte_ix <= '0;
      r_last_ix <= '0;
      r_32bit   <= 1'b0;
      r_shift   <= '0;
      r_gap_cnt <= '0;
      r_sync    <= 1'b0;
    end else begin
      r_sync <= (r_fsm == S_GAP) && !bus.regCtrlInit &&
                (r_gap_cnt == GAP_CNT_W'(RESET_CYCLES - 2));
      case (r_fsm)
        S_IDLE: begin
          r_bit_cnt <= '0;
          r_bit_num <= '0;
          r_byte_ix <= '0;
          r_gap_cnt <= '0;
          if (w_fsm_nxt == S_DATA) begin
            r_32bit   <= bus.regCtrl32bit;
            r_last_ix <= w_last_ix;
          end
        end
        S_DATA: begin
          r_bit_cnt <= w_bit_end ? '0 : r_bit_cnt + BIT_CNT_W'(1);
          if (w_byte_first)   r_shift <= w_bit_end ? {bus.pixelByte[6:0], 1'b0} : bus.pixelByte;
          else if (w_bit_end) r_shift <= {r_shift[6:0], 1'b0};
          if (w_bit_end)      r_bit_num <= w_byte_end ? 3'd0 : r_bit_num + 3'd1;
          if (w_byte_end && !w_last_byte) r_byte_ix <= w_ix_nxt[BUFFER_BITS-1:0];
        end
        S_GAP: begin
          r_gap_cnt <= w_gap_end ? '0 : r_gap_cnt + GAP_CNT_W'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_anton_neopixel_stream.sv
// Bench for anton_neopixel_stream: RAM model, waveform decoder and a byte scoreboard.
module tb_anton_neopixel_stream;
  localparam int unsigned BUFFER_END  = 7;
  localparam int unsigned BUFFER_BITS = 3;

  logic busClk;
  logic busReset;
  logic neoData;

  anton_neopixel_stream_if #(.BUFFER_BITS(BUFFER_BITS)) bus ();

  anton_neopixel_stream dut (
    .busClk   (busClk),
    .busReset (busReset),
    .bus      (bus.slave),
    .neoData  (neoData)
  );

  initial busClk = 1'b0;
  always #5 busClk = ~busClk;

  logic [7:0] ram [0:BUFFER_END];
  always @(posedge busClk) bus.pixelByte <= ram[bus.pixelIxComb];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] exp_q [$];

  function automatic int push_expected(input logic lim, input logic [12:0] mx, input logic b32);
    int last;
    int n;
    n    = 0;
    last = !lim ? BUFFER_END : ((mx > 13'(BUFFER_END)) ? BUFFER_END : int'(mx));
    for (int i = 0; i <= last; i++) begin
      if (!(b32 && (i % 4) == 3)) begin
        exp_q.push_back(ram[i]);
        n++;
      end
    end
    return n;
  endfunction

  // Waveform decoder, sampled on the falling clock edge.
  int         cyc = 0;
  int         sync_cnt = 0;
  int         data_clks = 0;
  int         bytes_done = 0;
  int         gap_len = 0;
  int         idle_run = 0;
  int         last_data_cyc = 0;
  int         last_rise = 0;
  int         frame_bits = 0;
  int         hi = 0;
  int         nbits = 0;
  logic [7:0] asm_byte = '0;
  logic [7:0] exp_byte;
  logic       prev_neo = 1'b0;

  always @(negedge busClk) begin
    cyc++;
    if (bus.streamSyncOf === 1'b1) begin
      sync_cnt++;
      check("sync_after_data", 32'(cyc - last_data_cyc), 32'd400);
    end
    if (bus.state === 1'b0) begin
      if (idle_run > 0) gap_len = idle_run;
      idle_run      = 0;
      data_clks++;
      last_data_cyc = cyc;
    end else begin
      idle_run++;
      hi         = 0;
      nbits      = 0;
      frame_bits = 0;
    end
    if (neoData === 1'b1) begin
      if (!prev_neo) begin
        if (frame_bits > 0) check("bit_period", 32'(cyc - last_rise), 32'd10);
        last_rise = cyc;
      end
      hi++;
    end else if (prev_neo && bus.state === 1'b0) begin
      check("high_time", 32'(hi), (hi > 4) ? 32'd6 : 32'd3);
      asm_byte = {asm_byte[6:0], (hi > 4)};
      nbits++;
      frame_bits++;
      hi = 0;
      if (nbits == 8) begin
        nbits = 0;
        bytes_done++;
        if (exp_q.size() == 0) begin
          check("byte_unexpected", {24'h0, asm_byte}, 32'hDEADBEEF);
        end else begin
          exp_byte = exp_q.pop_front();
          check("byte", {24'h0, asm_byte}, {24'h0, exp_byte});
        end
      end
    end
    prev_neo = (neoData === 1'b1);
  end

  // Waits for n sync pulses; run is released on the last so the frame does not repeat.
  task automatic wait_syncs(input int n, input string tag);
    int seen;
    seen = 0;
    for (int c = 0; c < 8000 && seen < n; c++) begin
      @(negedge busClk);
      if (bus.streamSyncOf === 1'b1) seen++;
    end
    bus.regCtrlRun = 1'b0;
    if (seen < n) check({tag, "_timeout"}, 32'(seen), 32'(n));
  endtask

  task automatic run_frame(input logic lim, input logic [12:0] mx, input logic b32,
                           input string tag);
    int s0, d0, b0, n;
    s0 = sync_cnt; d0 = data_clks; b0 = bytes_done;
    n  = push_expected(lim, mx, b32);
    bus.regCtrlLimit = lim;
    bus.regMax       = mx;
    bus.regCtrl32bit = b32;
    bus.regCtrlRun   = 1'b1;
    wait_syncs(1, tag);
    repeat (20) @(negedge busClk);
    check({tag, "_bytes"},     32'(bytes_done - b0), 32'(n));
    check({tag, "_data_clks"}, 32'(data_clks - d0),  32'(80 * n));
    check({tag, "_queue"},     32'(exp_q.size()),    32'd0);
    check({tag, "_syncs"},     32'(sync_cnt - s0),   32'd1);
    check({tag, "_idle"},      {30'h0, bus.state, neoData}, 32'b10);
  endtask

  int s0, d0, b0, n;

  initial begin
    for (int i = 0; i <= BUFFER_END; i++) ram[i] = 8'(8'h30 + 8'h17 * i);
    ram[0]           = 8'hA5;
    busReset         = 1'b1;
    bus.regMax       = '0;
    bus.regCtrlLimit = 1'b0;
    bus.regCtrlRun   = 1'b0;
    bus.regCtrl32bit = 1'b0;
    bus.regCtrlInit  = 1'b0;
    repeat (4) @(negedge busClk);
    check("rst_neo",   {31'h0, neoData},          32'd0);
    check("rst_state", {31'h0, bus.state},        32'd1);
    check("rst_sync",  {31'h0, bus.streamSyncOf}, 32'd0);
    check("rst_ix",    32'(bus.pixelIxComb),      32'd0);
    busReset = 1'b0;
    repeat (3) @(negedge busClk);

    run_frame(1'b1, 13'd0,    1'b0, "single");
    run_frame(1'b1, 13'd5,    1'b0, "order");
    run_frame(1'b1, 13'd7,    1'b1, "mode32");
    run_frame(1'b1, 13'd8191, 1'b0, "clamp");
    run_frame(1'b0, 13'd2,    1'b0, "nolimit");

    // Init holds the block idle even with run asserted.
    s0 = sync_cnt;
    bus.regCtrlInit = 1'b1;
    bus.regCtrlRun  = 1'b1;
    repeat (20) @(negedge busClk);
    check("init_state", {31'h0, bus.state}, 32'd1);
    check("init_neo",   {31'h0, neoData},   32'd0);
    check("init_syncs", 32'(sync_cnt - s0), 32'd0);
    bus.regCtrlRun  = 1'b0;
    bus.regCtrlInit = 1'b0;
    repeat (3) @(negedge busClk);

    // Loop mode: two back-to-back frames of two bytes.
    s0 = sync_cnt; b0 = bytes_done;
    n  = push_expected(1'b1, 13'd1, 1'b0);
    n += push_expected(1'b1, 13'd1, 1'b0);
    bus.regCtrlLimit = 1'b1;
    bus.regMax       = 13'd1;
    bus.regCtrl32bit = 1'b0;
    bus.regCtrlRun   = 1'b1;
    wait_syncs(2, "loop");
    repeat (20) @(negedge busClk);
    check("loop_bytes", 32'(bytes_done - b0), 32'(n));
    check("loop_syncs", 32'(sync_cnt - s0),   32'd2);
    check("loop_gap",   32'(gap_len),         32'd401);
    check("loop_queue", 32'(exp_q.size()),    32'd0);

    // Abort with a one-clock reset in the middle of byte 2, then a fresh full frame.
    s0 = sync_cnt; b0 = bytes_done;
    void'(push_expected(1'b0, 13'd0, 1'b0));
    bus.regCtrlLimit = 1'b0;
    bus.regCtrlRun   = 1'b1;
    for (int c = 0; c < 1000 && bytes_done < b0 + 2; c++) @(negedge busClk);
    check("abort_reach", 32'(bytes_done - b0), 32'd2);
    repeat (30) @(negedge busClk);
    check("abort_pre_state", {31'h0, bus.state}, 32'd0);
    busReset = 1'b1;
    @(negedge busClk);
    check("abort_neo",   {31'h0, neoData},      32'd0);
    check("abort_state", {31'h0, bus.state},    32'd1);
    check("abort_ix",    32'(bus.pixelIxComb),  32'd0);
    check("abort_syncs", 32'(sync_cnt - s0),    32'd0);
    busReset = 1'b0;
    exp_q.delete();
    b0 = bytes_done; d0 = data_clks;
    n  = push_expected(1'b0, 13'd0, 1'b0);
    wait_syncs(1, "restart");
    repeat (20) @(negedge busClk);
    check("restart_bytes",     32'(bytes_done - b0), 32'(n));
    check("restart_data_clks", 32'(data_clks - d0),  32'(80 * n));
    check("restart_syncs",     32'(sync_cnt - s0),   32'd1);
    check("restart_queue",     32'(exp_q.size()),    32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/anton_neopixel_stream.md
Name: anton_neopixel_stream

Overview:
- Downstream consumer of the neopixel register/frame-buffer block.
- Walks the pixel byte buffer by driving a combinational byte index into the two-port RAM, and serialises each returned byte MSB-first onto a single WS2812-style data line.
- After each frame, holds the line low for a latch/reset gap, then pulses streamSyncOf so the register block can clear or keep regCtrlRun (loop mode).
- Reports its phase through state.

Parameters:
- BUFFER_END, 7, last valid byte index of the pixel RAM (same value the register block uses).
- BUFFER_BITS, CLOG2(BUFFER_END+1), localparam, width of the byte index.
- BIT_CYCLES, 10, clocks per data bit (1.25 us at 8 MHz).
- T0H_CYCLES, 3, high time of a '0' bit, in clocks.
- T1H_CYCLES, 6, high time of a '1' bit, in clocks.
- RESET_CYCLES, 400, low clocks of the latch gap after a frame.

Ports:
- busClk  in  1  system clock, shared with the register block.
- busReset  in  1  synchronous reset, active-high.
- regMax  in  13  last byte index sent when regCtrlLimit=1.
- regCtrlLimit  in  1  1: frame ends at regMax; 0: frame ends at BUFFER_END.
- regCtrlRun  in  1  frame request/permission.
- regCtrl32bit  in  1  1: 4 bytes per pixel, 4th byte skipped.
- regCtrlInit  in  1  1: forces IDLE (same effect as reset, registers untouched).
- pixelIxComb  out  BUFFER_BITS  byte index presented to the RAM read port.
- pixelByte  in  8  RAM data, valid one clock after pixelIxComb.
- state  out  1  0 = transmitting data bits; 1 = IDLE or RESET gap.
- streamSyncOf  out  1  one-clock pulse at the end of the reset gap.
- neoData  out  1  serial LED data line.

Behaviour:
- Reset values (busReset=1 at an edge):
  - FSM=IDLE, neoData=0, streamSyncOf=0, state=1, pixelIxComb=0.
  - Bit and byte counters cleared.
- States: IDLE, DATA, GAP.
- IDLE:
  - neoData=0, pixelIxComb=0.
  - If regCtrlRun=1 and regCtrlInit=0: go to DATA next clock.
  - At that transition, latch regCtrlLimit, regCtrl32bit and lastIx for the whole frame.
  - lastIx = limit ? min(regMax, BUFFER_END) : BUFFER_END, compared at 13 bits.
- DATA:
  - Each bit lasts BIT_CYCLES clocks.
  - neoData=1 for the first T1H_CYCLES clocks of the bit if the bit is 1, or T0H_CYCLES clocks if it is 0; low for the remainder.
  - Bits are sent MSB first, 8 per byte.
- Shift register and RAM timing:
  - The shift register loads pixelByte on the first clock of each byte.
  - pixelIxComb must equal that byte's index on the preceding clock (1-cycle RAM latency).
  - pixelIxComb therefore advances combinationally on the last clock of bit 0 of the current byte.
  - The first byte (index 0) is already presented during IDLE.
- Next index = current+1; in 32-bit mode, indices with [1:0]==3 are skipped (next = current+2).
- Frame end:
  - After bit 0 of the byte at lastIx, go to GAP.
  - In 32-bit mode, a lastIx with [1:0]==3 is never sent; the frame ends at the preceding sent byte.
  - lastIx=0 sends exactly one byte.
- GAP:
  - neoData=0 for RESET_CYCLES clocks; streamSyncOf=1 on the last of them only.
  - Next state is IDLE; a loop restart is decided in IDLE one clock later, using the run value the register block updated on the pulse edge.
  - Result: RESET_CYCLES+1 clocks between frames.
- regCtrlRun dropping during DATA or GAP does not truncate the frame; the block finishes the frame and GAP.
- regCtrlInit=1, or busReset=1, in any state:
  - Abort to IDLE on that edge.
  - neoData=0 immediately from the next clock.
  - No streamSyncOf.
- state = (FSM != DATA).
- No arithmetic wraps: counters are sized to BIT_CYCLES, 8 bits and BUFFER_BITS; an index never exceeds lastIx.

Test Plan:
1. Frame timing: defaults, RAM[0]=0xA5, limit=1, regMax=0, run=1
   -> 8 bits with high times 6,3,6,3,3,6,3,6 clocks in 10-clock periods.
   -> Then 400 low clocks, streamSyncOf high on clock 400 only.
   -> Then IDLE.
2. Byte order: limit=1, regMax=5, RAM=0..5
   -> pixelIxComb sequence 0,1,2,3,4,5; 480 DATA clocks, state=0 throughout.
   -> Loop off: run cleared by the register block, no second frame.
3. 32-bit mode: regCtrl32bit=1, limit=1, regMax=7
   -> Bytes 0,1,2,4,5,6 sent (48 bits); indices 3 and 7 never transmitted.
4. Loop: run held 1
   -> Second frame's first rising neoData edge exactly 401 clocks after the last data clock of frame one.
   -> streamSyncOf once per frame.
5. Abort: busReset=1 for 1 clock mid-byte 2
   -> neoData=0 and state=1 next clock, pixelIxComb=0, no streamSyncOf.
   -> Fresh frame restarts from byte 0 when run=1.
6. Limit clamp: limit=1, regMax=8191, BUFFER_END=7
   -> Exactly 8 bytes sent.
   -> limit=0 with regMax=2 also sends 8 bytes.
